// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the set/reset pulse controller.
//   - Arbitration FSM state encoding (fixed numeric codes plus a typed enum).
//   - Default values for the debounce and pulse-width parameters.
package sr_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SET_P = 2'd1;
  localparam logic [1:0] ST_CLR_P = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_CNT_W           = 5;
  localparam int unsigned DEF_PULSE_WIDTH     = 2;

  // Width of the pulse-length counter; PULSE_WIDTH must fit in it.
  localparam int unsigned PW_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StSetP  = ST_SET_P,
    StClrP  = ST_CLR_P,
    StGuard = ST_GUARD
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw pushbutton: 2-flop synchroniser, debounce, rising-edge detect.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - synchronous active-low reset
//   btn_i   - raw asynchronous button level
//   level_o - debounced button level
//   rise_o  - registered one-cycle pulse on each 0->1 change of level_o
module btn_debounce
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised input disagrees with the
  // debounced level; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sr_pulse_ctrl.sv
// Turns two raw pushbuttons into clean, mutually exclusive, fixed-width S/R
// pulses for a downstream SR latch, with a guard cycle between pulses.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   set_btn_i  - raw set button, active high
//   clr_btn_i  - raw clear button, active high
//   s_o        - registered set pulse to latch S
//   r_o        - registered reset pulse to latch R
//   busy_o     - high whenever the arbiter is not idle
//   conflict_o - one-cycle pulse when set and clear requests collide
//   q_model_o  - expected latch Q (only with SR_PULSE_CTRL_QMODEL_EN defined)
module sr_pulse_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned PULSE_WIDTH     = DEF_PULSE_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn_i,
  input  logic clr_btn_i,
  output logic s_o,
  output logic r_o,
  output logic busy_o,
  output logic conflict_o
`ifdef SR_PULSE_CTRL_QMODEL_EN
  ,
  output logic q_model_o
`endif
);

  logic set_rise, clr_rise;
  logic set_level_unused, clr_level_unused;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (set_btn_i),
    .level_o(set_level_unused),
    .rise_o (set_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (clr_btn_i),
    .level_o(clr_level_unused),
    .rise_o (clr_rise)
  );

  state_e              state_q, state_d;
  logic [PW_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                set_pend_q, set_pend_d;
  logic                clr_pend_q, clr_pend_d;
  logic                s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;
  logic                set_req, clr_req;

  // In IDLE a pending flag counts exactly like a fresh request.
  assign set_req = set_rise | set_pend_q;
  assign clr_req = clr_rise | clr_pend_q;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    set_pend_d = set_pend_q;
    clr_pend_d = clr_pend_q;
    conflict_d = 1'b0;

    // Requests arriving while busy are remembered once; repeats are dropped.
    if (state_q != StIdle) begin
      if (set_rise) set_pend_d = 1'b1;
      if (clr_rise) clr_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (set_req && clr_req) begin
          conflict_d = 1'b1;
          set_pend_d = 1'b0;
          clr_pend_d = 1'b0;
        end else if (set_req) begin
          state_d    = StSetP;
          wcnt_d     = '0;
          set_pend_d = 1'b0;
        end else if (clr_req) begin
          state_d    = StClrP;
          wcnt_d     = '0;
          clr_pend_d = 1'b0;
        end
      end
      StSetP, StClrP: begin
        if (wcnt_q == PW_CNT_W'(PULSE_WIDTH - 1)) begin
          state_d = StGuard;
        end else begin
          wcnt_d = wcnt_q + PW_CNT_W'(1);
        end
      end
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    s_d    = (state_d == StSetP);
    r_d    = (state_d == StClrP);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      set_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      set_pend_q <= set_pend_d;
      clr_pend_q <= clr_pend_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign s_o        = s_q;
  assign r_o        = r_q;
  assign busy_o     = busy_q;
  assign conflict_o = conflict_q;

`ifdef SR_PULSE_CTRL_QMODEL_EN
  logic q_q, q_d;

  // Tracks what the downstream latch should hold after each pulse starts.
  always_comb begin
    q_d = q_q;
    if (s_d && !s_q) begin
      q_d = 1'b1;
    end else if (r_d && !r_q) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_model_o = q_q;
`endif

endmodule
